// File: rtl/disp_mux_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : disp_mux_scheduler
// Purpose  : Time-multiplexing scheduler for a dual seven-segment display.
//            It cycles BLANK1 -> SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 ...
//            A blanking slot with both displays off separates the two show
//            slots so that segment data never ghosts onto the wrong digit.
//            All outputs are registered, so there is no combinational path
//            from the inputs to the outputs.
// Ports    : clk        - system clock
//            reset      - synchronous, active-low reset
//            en         - scheduler enable; low forces a fresh BLANK1
//            s1 [3:0]   - digit for display 1 (left), sampled on SHOW0 entry
//            s2 [3:0]   - digit for display 2 (right), sampled on SHOW1 entry
//            disps[1:0] - display enables; [1] = display 1, [0] = display 2
//            sout[3:0]  - digit routed to the downstream segment decoder
//            frame_done - single-cycle pulse on the first cycle of SHOW0
// Revision : 1.0 - initial release
// ============================================================================
module disp_mux_scheduler #(
  parameter int DWELL_CYCLES = 2097152,
  parameter int BLANK_CYCLES = 1024,
  parameter int CNT_W        = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  output logic [1:0] disps,
  output logic [3:0] sout,
  output logic       frame_done
);

  // Terminal counts, one below each slot length.
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    BLANK1 = 2'd0,
    SHOW0  = 2'd1,
    BLANK0 = 2'd2,
    SHOW1  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       disps_nxt;
  logic [3:0]       sout_nxt;
  logic             frame_done_nxt;
  logic             slot_last;

  // State and output registers. Reset dominates enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= BLANK1;
      cnt        <= '0;
      disps      <= 2'b00;
      sout       <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      disps      <= disps_nxt;
      sout       <= sout_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Next-state and next-output logic. The output registers are loaded on
  // the same edge as the state change, so the display enables switch
  // exactly when a slot begins and the digit is captured only at slot
  // entry (it does not follow s1/s2 mid-slot).
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + 1'b1;
    disps_nxt      = disps;
    sout_nxt       = sout;
    frame_done_nxt = 1'b0;

    if ((state == SHOW0) || (state == SHOW1)) begin
      slot_last = (cnt == DWELL_LAST);
    end else begin
      slot_last = (cnt == BLANK_LAST);
    end

    if (!en) begin
      // Park in a fresh BLANK1 so that re-enabling behaves like reset
      // release; sout is deliberately left untouched.
      state_nxt = BLANK1;
      cnt_nxt   = '0;
      disps_nxt = 2'b00;
    end else if (slot_last) begin
      cnt_nxt = '0;
      unique case (state)
        BLANK1: begin
          state_nxt      = SHOW0;
          disps_nxt      = 2'b10;
          sout_nxt       = s1;
          frame_done_nxt = 1'b1;
        end
        SHOW0: begin
          state_nxt = BLANK0;
          disps_nxt = 2'b00;
        end
        BLANK0: begin
          state_nxt = SHOW1;
          disps_nxt = 2'b01;
          sout_nxt  = s2;
        end
        SHOW1: begin
          state_nxt = BLANK1;
          disps_nxt = 2'b00;
        end
        default: begin
          state_nxt = BLANK1;
          disps_nxt = 2'b00;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disp_mux_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_mux_scheduler
// Purpose  : Self-checking bench for disp_mux_scheduler. Two instances run
//            side by side on shared stimulus: one with DWELL=4/BLANK=2 and
//            one with the single-cycle corner DWELL=1/BLANK=1. A reference
//            model derives the expected outputs from the position inside
//            the frame period, counted from the last reset or disable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_mux_scheduler;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] s1;
  logic [3:0] s2;
  logic [1:0] disps_a, disps_b;
  logic [3:0] sout_a, sout_b;
  logic       fd_a, fd_b;

  int n_cmp;
  int n_bad;

  disp_mux_scheduler #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .CNT_W(3)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .s1         (s1),
    .s2         (s2),
    .disps      (disps_a),
    .sout       (sout_a),
    .frame_done (fd_a)
  );

  disp_mux_scheduler #(.DWELL_CYCLES(1), .BLANK_CYCLES(1), .CNT_W(1)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .s1         (s1),
    .s2         (s2),
    .disps      (disps_b),
    .sout       (sout_b),
    .frame_done (fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         mt    [2];
  logic [1:0] mdisp [2];
  logic [3:0] msout [2];
  logic       mfd   [2];

  function automatic int dwell_of(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int blank_of(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Frame position p in [0, 2*(D+B)): [0,B) blank, [B,B+D) show left,
  // [B+D,2B+D) blank, [2B+D,2B+2D) show right. t counts enabled edges
  // since the last reset or disable.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int d;
      int b;
      int p;
      d = dwell_of(k);
      b = blank_of(k);
      if (!reset) begin
        mt[k]    = 0;
        msout[k] = 4'h0;
      end else if (!en) begin
        mt[k] = 0;
      end else begin
        mt[k] = mt[k] + 1;
      end
      p = mt[k] % (2 * (d + b));
      if (p < b)              mdisp[k] = 2'b00;
      else if (p < b + d)     mdisp[k] = 2'b10;
      else if (p < 2 * b + d) mdisp[k] = 2'b00;
      else                    mdisp[k] = 2'b01;
      mfd[k] = (p == b);
      if (p == b)          msout[k] = s1;
      else if (p == 2*b+d) msout[k] = s2;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: model advances on the edge, DUT compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_a_disps", int'(disps_a), int'(mdisp[0]));
    chk("model_a_sout",  int'(sout_a),  int'(msout[0]));
    chk("model_a_fd",    int'(fd_a),    int'(mfd[0]));
    chk("model_b_disps", int'(disps_b), int'(mdisp[1]));
    chk("model_b_sout",  int'(sout_b),  int'(msout[1]));
    chk("model_b_fd",    int'(fd_b),    int'(mfd[1]));
  endtask

  task automatic step_exp(input string name, input logic [1:0] d,
                          input logic [3:0] s, input logic f);
    step();
    chk({name, "_disps"}, int'(disps_a), int'(d));
    chk({name, "_sout"},  int'(sout_a),  int'(s));
    chk({name, "_fd"},    int'(fd_a),    int'(f));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] disps;
    logic [3:0] sout;
    logic       fd;
  } vec_t;

  vec_t vtab[15];
  logic [1:0] bpat[4];

  task automatic run_table();
    for (int j = 0; j < 15; j++) begin
      reset = vtab[j].rst;
      en    = vtab[j].en;
      s1    = vtab[j].s1;
      s2    = vtab[j].s2;
      step();
      chk($sformatf("tab%0d_disps", j), int'(disps_a), int'(vtab[j].disps));
      chk($sformatf("tab%0d_sout", j),  int'(sout_a),  int'(vtab[j].sout));
      chk($sformatf("tab%0d_fd", j),    int'(fd_a),    int'(vtab[j].fd));
      if (j == 0) begin
        chk("b_reset_disps", int'(disps_b), 0);
      end else begin
        chk($sformatf("b%0d_disps", j), int'(disps_b), int'(bpat[(j-1)%4]));
        chk($sformatf("b%0d_fd", j),    int'(fd_b),    int'(((j-1)%4) == 0));
      end
    end
  endtask

  initial begin
    logic [1:0] last_nz;
    int         zeros;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    en    = 1'b0;
    s1    = 4'h0;
    s2    = 4'h0;
    for (int k = 0; k < 2; k++) begin
      mt[k] = 0; mdisp[k] = 2'b00; msout[k] = 4'h0; mfd[k] = 1'b0;
    end

    //           rst   en    s1    s2    disps  sout  fd
    vtab[0]  = '{1'b0, 1'b1, 4'h3, 4'hA, 2'b00, 4'h0, 1'b0};
    vtab[1]  = '{1'b1, 1'b1, 4'h3, 4'hA, 2'b00, 4'h0, 1'b0};
    vtab[2]  = '{1'b1, 1'b1, 4'h3, 4'hA, 2'b10, 4'h3, 1'b1};
    vtab[3]  = '{1'b1, 1'b1, 4'h3, 4'hA, 2'b10, 4'h3, 1'b0};
    vtab[4]  = '{1'b1, 1'b1, 4'h7, 4'hA, 2'b10, 4'h3, 1'b0};
    vtab[5]  = '{1'b1, 1'b1, 4'h7, 4'hA, 2'b10, 4'h3, 1'b0};
    vtab[6]  = '{1'b1, 1'b1, 4'h7, 4'hA, 2'b00, 4'h3, 1'b0};
    vtab[7]  = '{1'b1, 1'b1, 4'h7, 4'hA, 2'b00, 4'h3, 1'b0};
    vtab[8]  = '{1'b1, 1'b1, 4'h7, 4'hA, 2'b01, 4'hA, 1'b0};
    vtab[9]  = '{1'b1, 1'b1, 4'h7, 4'hA, 2'b01, 4'hA, 1'b0};
    vtab[10] = '{1'b1, 1'b1, 4'h7, 4'hA, 2'b01, 4'hA, 1'b0};
    vtab[11] = '{1'b1, 1'b1, 4'h7, 4'hA, 2'b01, 4'hA, 1'b0};
    vtab[12] = '{1'b1, 1'b1, 4'h7, 4'hA, 2'b00, 4'hA, 1'b0};
    vtab[13] = '{1'b1, 1'b1, 4'h7, 4'hA, 2'b00, 4'hA, 1'b0};
    vtab[14] = '{1'b1, 1'b1, 4'h7, 4'hA, 2'b10, 4'h7, 1'b1};
    bpat[0] = 2'b10; bpat[1] = 2'b00; bpat[2] = 2'b01; bpat[3] = 2'b00;

    // Reset release, first frame, mid-slot s1 change, single-cycle slots.
    run_table();

    // Finish SHOW0, pass BLANK0, enter SHOW1 showing A.
    step_exp("show0_a", 2'b10, 4'h7, 1'b0);
    step_exp("show0_b", 2'b10, 4'h7, 1'b0);
    step_exp("show0_c", 2'b10, 4'h7, 1'b0);
    step_exp("blank0_a", 2'b00, 4'h7, 1'b0);
    step_exp("blank0_b", 2'b00, 4'h7, 1'b0);
    step_exp("show1_in", 2'b01, 4'hA, 1'b0);

    // Disable for three edges during SHOW1.
    en = 1'b0;
    for (int i = 0; i < 3; i++) step_exp($sformatf("en_lo%0d", i), 2'b00, 4'hA, 1'b0);
    en = 1'b1;
    step_exp("en_re_blank", 2'b00, 4'hA, 1'b0);
    step_exp("en_re_show0", 2'b10, 4'h7, 1'b1);
    step_exp("en_re_show0b", 2'b10, 4'h7, 1'b0);

    // Reset mid-SHOW0, then the first scenario must repeat exactly.
    reset = 1'b0;
    step_exp("rst_mid", 2'b00, 4'h0, 1'b0);
    run_table();

    // Sweep all 16x16 digit pairs with the blanking invariant checked.
    reset = 1'b0;
    step();
    reset   = 1'b1;
    last_nz = 2'b00;
    zeros   = 0;
    for (int i = 0; i < 256; i++) begin
      s1 = 4'(i);
      s2 = 4'(i >> 4);
      step();
      chk("never_11", int'(disps_a == 2'b11), 0);
      if (disps_a == 2'b00) begin
        zeros++;
      end else begin
        if (last_nz != 2'b00 && disps_a != last_nz)
          chk("blank_gap", zeros, 2);
        last_nz = disps_a;
        zeros   = 0;
      end
    end

    // Random inputs with occasional disables and resets.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) != 0);
      en    = ($urandom_range(0, 11) != 0);
      s1    = 4'($urandom);
      s2    = 4'($urandom);
      step();
      chk("rand_never_11", int'(disps_a == 2'b11 || disps_b == 2'b11), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
